motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver.sv | 125 ++++++++++++
 tb/tb_motor_pwm_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// Two-wheel PWM motor driver: command-to-duty mapping, per-period duty ramping
// and a command watchdog that forces a failsafe stop when commands stop arriving.
module motor_pwm_driver #(
    parameter int PWM_PERIOD      = 1000,
    parameter int DUTY_CRUISE     = 1000,
    parameter int DUTY_SLOW       = 500,
    parameter int RAMP_STEP       = 50,
    parameter int TIMEOUT_PERIODS = 50
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [2:0]                           drive_command,
    input  logic                                 drive_valid,
    output logic                                 cmd_ready,
    output logic                                 pwm_left,
    output logic                                 pwm_right,
    output logic [$clog2(PWM_PERIOD+1)-1:0]      duty_left,
    output logic [$clog2(PWM_PERIOD+1)-1:0]      duty_right,
    output logic                                 settled,
    output logic                                 timeout
);

    localparam int W   = $clog2(PWM_PERIOD + 1);
    localparam int WDW = $clog2(TIMEOUT_PERIODS + 1);

    localparam logic [W-1:0]   LAST    = W'(PWM_PERIOD - 1);
    localparam logic [W-1:0]   CRUISE  = W'(DUTY_CRUISE);
    localparam logic [W-1:0]   SLOW    = W'(DUTY_SLOW);
    localparam logic [W-1:0]   STEP    = W'(RAMP_STEP);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_PERIODS - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_PERIODS);

    logic [W-1:0]   counter;
    logic [W-1:0]   target_left;
    logic [W-1:0]   target_right;
    logic [W-1:0]   cmd_left;
    logic [W-1:0]   cmd_right;
    logic [W-1:0]   eff_left;
    logic [W-1:0]   eff_right;
    logic [WDW-1:0] watchdog;
    logic           accept;
    logic           boundary;
    logic           fire;

    // Step toward the target by at most STEP, landing exactly on it.
    function automatic logic [W-1:0] ramp(input logic [W-1:0] duty,
                                          input logic [W-1:0] target);
        logic [W-1:0] diff;
        if (duty < target) begin
            diff = target - duty;
            ramp = (int'(diff) > RAMP_STEP) ? duty + STEP : target;
        end else begin
            diff = duty - target;
            ramp = (int'(diff) > RAMP_STEP) ? duty - STEP : target;
        end
    endfunction

    always_comb begin
        cmd_left  = '0;
        cmd_right = '0;
        case (drive_command)
            3'd1: cmd_right = CRUISE;
            3'd2: begin cmd_left = SLOW;   cmd_right = CRUISE; end
            3'd3: begin cmd_left = CRUISE; cmd_right = CRUISE; end
            3'd4: begin cmd_left = CRUISE; cmd_right = SLOW;   end
            3'd5: cmd_left = CRUISE;
            default: ;
        endcase
    end

    assign cmd_ready = reset_n;
    assign accept    = drive_valid && cmd_ready;
    assign boundary  = (counter == LAST);
    // An accept on the boundary edge always wins over the watchdog expiring.
    assign fire      = boundary && !accept && (watchdog == WD_LAST);
    assign eff_left  = accept ? cmd_left  : target_left;
    assign eff_right = accept ? cmd_right : target_right;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else begin
            counter <= boundary ? '0 : counter + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_left  <= '0;
            target_right <= '0;
            watchdog     <= '0;
            timeout      <= 1'b0;
        end else if (accept) begin
            target_left  <= cmd_left;
            target_right <= cmd_right;
            watchdog     <= '0;
            timeout      <= 1'b0;
        end else if (fire) begin
            target_left  <= '0;
            target_right <= '0;
            watchdog     <= WD_MAX;
            timeout      <= 1'b1;
        end else if (boundary && watchdog != WD_MAX) begin
            watchdog     <= watchdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_left  <= '0;
            duty_right <= '0;
        end else if (fire) begin
            duty_left  <= '0;
            duty_right <= '0;
        end else if (boundary) begin
            duty_left  <= ramp(duty_left, eff_left);
            duty_right <= ramp(duty_right, eff_right);
        end
    end

    assign pwm_left  = (counter < duty_left);
    assign pwm_right = (counter < duty_right);
    assign settled   = (duty_left == target_left) && (duty_right == target_right);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with a small configuration
// (period 100, cruise 100, slow 50, step 25, timeout 4 periods).
module tb_motor_pwm_driver;

    localparam int P = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] drive_command;
    logic       drive_valid;
    logic       cmd_ready;
    logic       pwm_left;
    logic       pwm_right;
    logic [6:0] duty_left;
    logic [6:0] duty_right;
    logic       settled;
    logic       timeout;

    int check_count = 0;
    int pass_count  = 0;
    int phase       = 0;

    motor_pwm_driver #(
        .PWM_PERIOD(100), .DUTY_CRUISE(100), .DUTY_SLOW(50),
        .RAMP_STEP(25), .TIMEOUT_PERIODS(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .drive_command(drive_command),
        .drive_valid(drive_valid), .cmd_ready(cmd_ready),
        .pwm_left(pwm_left), .pwm_right(pwm_right),
        .duty_left(duty_left), .duty_right(duty_right),
        .settled(settled), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // phase mirrors the expected counter value just after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        phase = (phase == P - 1) ? 0 : phase + 1;
    endtask

    task automatic to_last();
        while (phase != P - 1) tick();
    endtask

    task automatic to_boundary();
        to_last();
        tick();
    endtask

    task automatic count_high(output int nl, output int nr);
        nl = 0;
        nr = 0;
        for (int i = 0; i < P; i++) begin
            nl += int'(pwm_left);
            nr += int'(pwm_right);
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_valid = 1'b0;
        drive_command = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_count++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
        else pass_count++;
        check_count++;
        if (duty_left !== 7'd0 || duty_right !== 7'd0)
            $display("FAIL reset_duty: got %0d/%0d expected 0/0", duty_left, duty_right);
        else pass_count++;
        check_count++;
        if (pwm_left !== 1'b0 || pwm_right !== 1'b0)
            $display("FAIL reset_pwm: got %b/%b expected 0/0", pwm_left, pwm_right);
        else pass_count++;
        check_count++;
        if (settled !== 1'b1 || timeout !== 1'b0)
            $display("FAIL reset_flags: settled %b timeout %b expected 1 0", settled, timeout);
        else pass_count++;
        reset_n = 1'b1;
        phase = 0;
        #1;
        check_count++;
        if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready);
        else pass_count++;
    endtask

    task automatic test_straight_ramp();
        int nl, nr;
        drive_command = 3'd3;
        drive_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            to_boundary();
            check_count++;
            if (int'(duty_left) !== 25 * k || int'(duty_right) !== 25 * k)
                $display("FAIL straight_ramp_%0d: got %0d/%0d expected %0d/%0d",
                         k, duty_left, duty_right, 25 * k, 25 * k);
            else pass_count++;
            check_count++;
            if (settled !== (k == 4))
                $display("FAIL straight_settled_%0d: got %b expected %b", k, settled, k == 4);
            else pass_count++;
        end
        count_high(nl, nr);
        check_count++;
        if (nl !== 100 || nr !== 100)
            $display("FAIL straight_pwm_high: got %0d/%0d expected 100/100", nl, nr);
        else pass_count++;
    endtask

    task automatic test_left();
        int nl, nr;
        drive_command = 3'd2;
        for (int k = 1; k <= 2; k++) begin
            to_boundary();
            check_count++;
            if (int'(duty_left) !== 100 - 25 * k || duty_right !== 7'd100)
                $display("FAIL left_ramp_%0d: got %0d/%0d expected %0d/100",
                         k, duty_left, duty_right, 100 - 25 * k);
            else pass_count++;
        end
        count_high(nl, nr);
        check_count++;
        if (nl !== 50 || nr !== 100)
            $display("FAIL left_pwm_high: got %0d/%0d expected 50/100", nl, nr);
        else pass_count++;
    endtask

    task automatic test_stop_code7();
        drive_command = 3'd3;
        to_boundary();
        to_boundary();
        check_count++;
        if (duty_left !== 7'd100 || settled !== 1'b1)
            $display("FAIL code7_setup: got duty %0d settled %b expected 100 1", duty_left, settled);
        else pass_count++;
        drive_command = 3'd7;
        for (int k = 1; k <= 4; k++) begin
            to_boundary();
            check_count++;
            if (int'(duty_left) !== 100 - 25 * k || int'(duty_right) !== 100 - 25 * k ||
                settled !== (k == 4))
                $display("FAIL code7_ramp_%0d: got %0d/%0d settled %b expected %0d/%0d settled %b",
                         k, duty_left, duty_right, settled, 100 - 25 * k, 100 - 25 * k, k == 4);
            else pass_count++;
        end
    endtask

    task automatic test_fast_turns();
        logic [2:0] cmds [4] = '{3'd1, 3'd6, 3'd5, 3'd0};
        int         exp_l [4] = '{0, 0, 25, 0};
        int         exp_r [4] = '{25, 0, 0, 0};
        logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_command = cmds[i];
            to_boundary();
            check_count++;
            if (int'(duty_left) !== exp_l[i] || int'(duty_right) !== exp_r[i] || settled !== exp_s[i])
                $display("FAIL fast_cmd%0d: got %0d/%0d settled %b expected %0d/%0d settled %b",
                         cmds[i], duty_left, duty_right, settled, exp_l[i], exp_r[i], exp_s[i]);
            else pass_count++;
        end
    endtask

    task automatic test_timeout();
        drive_command = 3'd3;
        for (int k = 0; k < 4; k++) to_boundary();
        drive_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            to_boundary();
            check_count++;
            if (k < 4) begin
                if (timeout !== 1'b0 || duty_left !== 7'd100 || duty_right !== 7'd100)
                    $display("FAIL timeout_wait_%0d: got to %b duty %0d/%0d expected 0 100/100",
                             k, timeout, duty_left, duty_right);
                else pass_count++;
            end else begin
                if (timeout !== 1'b1 || duty_left !== 7'd0 || duty_right !== 7'd0 || settled !== 1'b1)
                    $display("FAIL timeout_fire: got to %b duty %0d/%0d settled %b expected 1 0/0 1",
                             timeout, duty_left, duty_right, settled);
                else pass_count++;
            end
        end
        drive_command = 3'd4;
        drive_valid = 1'b1;
        tick();
        drive_valid = 1'b0;
        check_count++;
        if (timeout !== 1'b0) $display("FAIL timeout_clear: got %b expected 0", timeout);
        else pass_count++;
        to_boundary();
        check_count++;
        if (duty_left !== 7'd25 || duty_right !== 7'd25)
            $display("FAIL timeout_reramp: got %0d/%0d expected 25/25", duty_left, duty_right);
        else pass_count++;
    endtask

    task automatic test_accept_at_boundary();
        to_boundary();
        to_boundary();
        check_count++;
        if (duty_left !== 7'd75 || duty_right !== 7'd50 || timeout !== 1'b0)
            $display("FAIL edge_setup: got %0d/%0d to %b expected 75/50 0",
                     duty_left, duty_right, timeout);
        else pass_count++;
        to_last();
        drive_valid = 1'b1;
        tick();
        drive_valid = 1'b0;
        check_count++;
        if (timeout !== 1'b0 || duty_left !== 7'd100 || duty_right !== 7'd50)
            $display("FAIL edge_accept: got to %b duty %0d/%0d expected 0 100/50",
                     timeout, duty_left, duty_right);
        else pass_count++;
        for (int k = 1; k <= 4; k++) begin
            to_boundary();
            check_count++;
            if (timeout !== (k == 4))
                $display("FAIL edge_watchdog_%0d: got %b expected %b", k, timeout, k == 4);
            else pass_count++;
        end
    endtask

    task automatic test_async_reset();
        drive_command = 3'd3;
        drive_valid = 1'b1;
        to_boundary();
        to_boundary();
        repeat (10) tick();
        check_count++;
        if (duty_left !== 7'd50 || pwm_left !== 1'b1)
            $display("FAIL async_setup: got duty %0d pwm %b expected 50 1", duty_left, pwm_left);
        else pass_count++;
        #2;
        reset_n = 1'b0;
        #1;
        check_count++;
        if (pwm_left !== 1'b0 || pwm_right !== 1'b0 || duty_left !== 7'd0 ||
            duty_right !== 7'd0 || cmd_ready !== 1'b0)
            $display("FAIL async_reset: got pwm %b/%b duty %0d/%0d ready %b expected 0/0 0/0 0",
                     pwm_left, pwm_right, duty_left, duty_right, cmd_ready);
        else pass_count++;
        repeat (3) @(posedge clk);
        #1;
        check_count++;
        if (cmd_ready !== 1'b0 || settled !== 1'b1 || duty_left !== 7'd0)
            $display("FAIL async_hold: got ready %b settled %b duty %0d expected 0 1 0",
                     cmd_ready, settled, duty_left);
        else pass_count++;
        reset_n = 1'b1;
        phase = 0;
        to_last();
        check_count++;
        if (duty_left !== 7'd0) $display("FAIL resume_before: got %0d expected 0", duty_left);
        else pass_count++;
        tick();
        check_count++;
        if (duty_left !== 7'd25 || duty_right !== 7'd25)
            $display("FAIL resume_first: got %0d/%0d expected 25/25", duty_left, duty_right);
        else pass_count++;
        drive_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_straight_ramp();
        test_left();
        test_stop_code7();
        test_fast_turns();
        test_timeout();
        test_accept_at_boundary();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
